// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback stage (also imported by decode):
//   ld_op_e    - load type carried down the pipeline with each instruction
//   rd_state_e - state of the writeback read-data tracker
//   ext8/ext16 - sign/zero extension helpers used by load_extract
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_op_e;

    // EMPTY: no instruction. FRESH: first cycle in WB, SRAM data is live.
    // HELD: stalled past the first cycle, SRAM data comes from the buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FRESH = 2'd1,
        ST_HELD  = 2'd2
    } rd_state_e;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic is_signed);
        return {{24{is_signed & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic is_signed);
        return {{16{is_signed & h[15]}}, h};
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
// MEM -> WB pipeline handshake and payload.
//   ms_valid       memory stage holds a valid instruction
//   ws_allowin     WB can accept an instruction this cycle
//   ms_pc          PC of the instruction
//   ms_alu_result  ALU result / load address
//   ms_rt_value    old rt content (LWL/LWR merge)
//   ms_dest        destination register
//   ms_rf_wen      instruction writes the register file
//   ms_load_op     load type
// Modports: master = memory stage, slave = writeback stage.
// -----------------------------------------------------------------------------
interface writeback_stage_if;
    import wb_pkg::*;

    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_rt_value;
    logic [4:0]  ms_dest;
    logic        ms_rf_wen;
    ld_op_e      ms_load_op;

    modport master (
        output ms_valid, ms_pc, ms_alu_result, ms_rt_value, ms_dest, ms_rf_wen, ms_load_op,
        input  ws_allowin
    );

    modport slave (
        input  ms_valid, ms_pc, ms_alu_result, ms_rt_value, ms_dest, ms_rf_wen, ms_load_op,
        output ws_allowin
    );

endinterface

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational load-data formatter (little-endian).
//   i_load_op    load type
//   i_off        byte offset (address bits [1:0])
//   i_alu_result result returned for non-load instructions
//   i_rdata      word read from memory
//   i_rt         old rt value, merged by LWL/LWR
//   o_wdata      register-file write data
// Build option: WB_UNALIGNED_LOAD_EN enables the LWL/LWR merge; without it
// both decode as a plain word load.
// -----------------------------------------------------------------------------
module load_extract
    import wb_pkg::*;
(
    input  ld_op_e      i_load_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt,
    output logic [31:0] o_wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_lwl;
    logic [31:0] w_lwr;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // off[0] is deliberately ignored: misalignment is trapped upstream.
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

`ifdef WB_UNALIGNED_LOAD_EN
    always_comb begin
        case (i_off)
            2'd0:    w_lwl = {i_rdata[7:0],  i_rt[23:0]};
            2'd1:    w_lwl = {i_rdata[15:0], i_rt[15:0]};
            2'd2:    w_lwl = {i_rdata[23:0], i_rt[7:0]};
            default: w_lwl = i_rdata;
        endcase
    end

    always_comb begin
        case (i_off)
            2'd0:    w_lwr = i_rdata;
            2'd1:    w_lwr = {i_rt[31:24], i_rdata[31:8]};
            2'd2:    w_lwr = {i_rt[31:16], i_rdata[31:16]};
            default: w_lwr = {i_rt[31:8],  i_rdata[31:24]};
        endcase
    end
`else
    logic w_unused_rt;
    assign w_unused_rt = ^i_rt;
    assign w_lwl       = i_rdata;
    assign w_lwr       = i_rdata;
`endif

    always_comb begin
        o_wdata = i_alu_result;
        case (i_load_op)
            LD_LB:   o_wdata = ext8(w_byte, 1'b1);
            LD_LBU:  o_wdata = ext8(w_byte, 1'b0);
            LD_LH:   o_wdata = ext16(w_half, 1'b1);
            LD_LHU:  o_wdata = ext16(w_half, 1'b0);
            LD_LW:   o_wdata = i_rdata;
            LD_LWL:  o_wdata = w_lwl;
            LD_LWR:  o_wdata = w_lwr;
            default: o_wdata = i_alu_result;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage: MEM/WB register, load-data formatting, register-file
// write port, WB forwarding bus and retired-instruction counter. SRAM read
// data arrives the cycle the instruction enters WB and is buffered so it
// survives a stall.
// Parameters: CNT_W (retire_count width), RESET_PC (debug_wb_pc when empty).
// Ports:
//   clk, reset          clock / asynchronous active-high reset
//   ms_bus (slave)      MEM -> WB handshake and payload
//   data_sram_rdata     SRAM read data for the instruction now in WB
//   ws_hold             external stall, freezes WB
//   rf_wen/waddr/wdata  register-file write port (one strobe per commit)
//   forward_wb_*        pending WB write (valid during stalls too)
//   debug_wb_pc         PC in WB, RESET_PC when empty
//   retire_count        committed-instruction counter (wraps)
// Build option: WB_UNALIGNED_LOAD_EN enables LWL/LWR merging in load_extract.
// -----------------------------------------------------------------------------
module writeback_stage
    import wb_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic             clk,
    input  logic             reset,
    writeback_stage_if.slave ms_bus,
    input  logic [31:0]      data_sram_rdata,
    input  logic             ws_hold,
    output logic             rf_wen,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             forward_wb_wen,
    output logic [4:0]       forward_wb_regsrc,
    output logic [31:0]      forward_wb_wdata,
    output logic [31:0]      debug_wb_pc,
    output logic [CNT_W-1:0] retire_count
);

    rd_state_e        r_state;
    rd_state_e        w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_alu_result;
    logic [31:0]      r_rt_value;
    logic [4:0]       r_dest;
    logic             r_rf_wen;
    ld_op_e           r_load_op;
    logic [31:0]      r_rdata_buf;
    logic [CNT_W-1:0] r_retire_count;

    logic             w_ws_valid;
    logic             w_allowin;
    logic             w_accept;
    logic             w_commit;
    logic             w_wr_nz;
    logic [31:0]      w_src_rdata;
    logic [31:0]      w_ext_wdata;

    // The FSM is the valid bit: any non-EMPTY state holds an instruction.
    assign w_ws_valid        = (r_state != ST_EMPTY);
    assign w_allowin         = !w_ws_valid || !ws_hold;
    assign ms_bus.ws_allowin = w_allowin;
    assign w_accept          = ms_bus.ms_valid && w_allowin;
    assign w_commit          = w_ws_valid && !ws_hold;
    assign w_wr_nz           = w_ws_valid && r_rf_wen && (r_dest != 5'd0);

    // MEM/WB pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= 32'd0;
            r_alu_result <= 32'd0;
            r_rt_value   <= 32'd0;
            r_dest       <= 5'd0;
            r_rf_wen     <= 1'b0;
            r_load_op    <= LD_NONE;
        end else if (w_accept) begin
            r_pc         <= ms_bus.ms_pc;
            r_alu_result <= ms_bus.ms_alu_result;
            r_rt_value   <= ms_bus.ms_rt_value;
            r_dest       <= ms_bus.ms_dest;
            r_rf_wen     <= ms_bus.ms_rf_wen;
            r_load_op    <= ms_bus.ms_load_op;
        end
    end

    // Read-data tracker: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read-data tracker: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FRESH;
                end
            end
            ST_FRESH, ST_HELD: begin
                if (ws_hold) begin
                    w_state_next = ST_HELD;
                end else if (w_accept) begin
                    w_state_next = ST_FRESH;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // SRAM data is only valid in the FRESH cycle; capture it then so a stall
    // keeps seeing the original word even if the SRAM output moves on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata_buf <= 32'd0;
        end else if (r_state == ST_FRESH) begin
            r_rdata_buf <= data_sram_rdata;
        end
    end

    assign w_src_rdata = (r_state == ST_HELD) ? r_rdata_buf : data_sram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_count <= '0;
        end else if (w_commit) begin
            r_retire_count <= r_retire_count + CNT_W'(1);
        end
    end

    load_extract u_load_extract (
        .i_load_op    (r_load_op),
        .i_off        (r_alu_result[1:0]),
        .i_alu_result (r_alu_result),
        .i_rdata      (w_src_rdata),
        .i_rt         (r_rt_value),
        .o_wdata      (w_ext_wdata)
    );

    // Address/data are zeroed while empty so stale contents never leak out.
    assign rf_wen            = w_commit && w_wr_nz;
    assign rf_waddr          = w_ws_valid ? r_dest : 5'd0;
    assign rf_wdata          = w_ws_valid ? w_ext_wdata : 32'd0;
    assign forward_wb_wen    = w_wr_nz;
    assign forward_wb_regsrc = rf_waddr;
    assign forward_wb_wdata  = rf_wdata;
    assign debug_wb_pc       = w_ws_valid ? r_pc : RESET_PC;
    assign retire_count      = r_retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Directed, table-driven bench for writeback_stage (CNT_W = 4 so the retire
// counter wrap is reachable). Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;
    import wb_pkg::*;

    localparam logic [31:0] RST_PC = 32'hbfc00000;
    localparam int          NVEC   = 14;

`ifdef WB_UNALIGNED_LOAD_EN
    localparam logic [31:0] LWL_EXP = 32'hCCDD3344;
    localparam logic [31:0] LWR_EXP = 32'h1122AABB;
`else
    localparam logic [31:0] LWL_EXP = 32'hAABBCCDD;
    localparam logic [31:0] LWR_EXP = 32'hAABBCCDD;
`endif

    typedef struct {
        ld_op_e      op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] rt;
        logic [4:0]  dest;
        logic        wen;
        logic [31:0] exp_wdata;
        logic        exp_wen;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_sram_rdata;
    logic        ws_hold;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        forward_wb_wen;
    logic [4:0]  forward_wb_regsrc;
    logic [31:0] forward_wb_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  retire_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    vec_t vecs [NVEC];

    writeback_stage_if bus ();

    writeback_stage #(.CNT_W(4), .RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_bus            (bus),
        .data_sram_rdata   (data_sram_rdata),
        .ws_hold           (ws_hold),
        .rf_wen            (rf_wen),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .forward_wb_wen    (forward_wb_wen),
        .forward_wb_regsrc (forward_wb_regsrc),
        .forward_wb_wdata  (forward_wb_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .retire_count      (retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ms(input logic v, input logic [31:0] pc, input ld_op_e op,
                            input logic [31:0] addr, input logic [31:0] rt,
                            input logic [4:0] dest, input logic wen);
        bus.ms_valid      = v;
        bus.ms_pc         = pc;
        bus.ms_load_op    = op;
        bus.ms_alu_result = addr;
        bus.ms_rt_value   = rt;
        bus.ms_dest       = dest;
        bus.ms_rf_wen     = wen;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [31:0] pc;
        v  = vecs[idx];
        pc = 32'h1000 + 32'(idx * 4);
        drive_ms(1'b1, pc, v.op, v.addr, v.rt, v.dest, v.wen);
        ws_hold = 1'b0;
        step();
        bus.ms_valid    = 1'b0;
        data_sram_rdata = v.rdata;
        @(negedge clk);
        chk($sformatf("vec%0d rf_wen", idx), 32'(rf_wen), 32'(v.exp_wen));
        chk($sformatf("vec%0d rf_wdata", idx), rf_wdata, v.exp_wdata);
        chk($sformatf("vec%0d fwd_wen", idx), 32'(forward_wb_wen), 32'(v.exp_wen));
        chk($sformatf("vec%0d fwd_wdata", idx), forward_wb_wdata, v.exp_wdata);
        chk($sformatf("vec%0d rf_waddr", idx), 32'(rf_waddr), 32'(v.dest));
        chk($sformatf("vec%0d pc", idx), debug_wb_pc, pc);
        step();
        exp_cnt++;
        $display("vec %0d op=%0d addr=%h rdata=%h -> wdata=%h wen=%0d", idx, v.op, v.addr,
                 v.rdata, v.exp_wdata, v.exp_wen);
    endtask

    initial begin
        vecs[0]  = '{LD_LB,   32'h80000002, 32'h12803456, 32'h0,        5'd2,  1'b1, 32'hFFFFFF80, 1'b1};
        vecs[1]  = '{LD_LBU,  32'h80000002, 32'h12803456, 32'h0,        5'd3,  1'b1, 32'h00000080, 1'b1};
        vecs[2]  = '{LD_LH,   32'h80000002, 32'h12803456, 32'h0,        5'd5,  1'b1, 32'h00001280, 1'b1};
        vecs[3]  = '{LD_LH,   32'h80000003, 32'h12803456, 32'h0,        5'd5,  1'b1, 32'h00001280, 1'b1};
        vecs[4]  = '{LD_LH,   32'h80000000, 32'h1234F00D, 32'h0,        5'd6,  1'b1, 32'hFFFFF00D, 1'b1};
        vecs[5]  = '{LD_LHU,  32'h80000000, 32'h1234F00D, 32'h0,        5'd6,  1'b1, 32'h0000F00D, 1'b1};
        vecs[6]  = '{LD_LW,   32'h80000004, 32'h12803456, 32'h0,        5'd8,  1'b1, 32'h12803456, 1'b1};
        vecs[7]  = '{LD_NONE, 32'h10000044, 32'hFFFFFFFF, 32'h0,        5'd9,  1'b1, 32'h10000044, 1'b1};
        vecs[8]  = '{LD_LB,   32'h80000003, 32'h8A000000, 32'h0,        5'd10, 1'b1, 32'hFFFFFF8A, 1'b1};
        vecs[9]  = '{LD_LW,   32'h8000000C, 32'h12345678, 32'h0,        5'd0,  1'b1, 32'h12345678, 1'b0};
        vecs[10] = '{LD_LW,   32'h80000010, 32'h87654321, 32'h0,        5'd11, 1'b0, 32'h87654321, 1'b0};
        vecs[11] = '{LD_LWL,  32'h80000001, 32'hAABBCCDD, 32'h11223344, 5'd12, 1'b1, LWL_EXP,      1'b1};
        vecs[12] = '{LD_LWR,  32'h80000002, 32'hAABBCCDD, 32'h11223344, 5'd13, 1'b1, LWR_EXP,      1'b1};
        vecs[13] = '{LD_LH,   32'h80000002, 32'h80001234, 32'h0,        5'd14, 1'b1, 32'hFFFF8000, 1'b1};

        reset           = 1'b1;
        ws_hold         = 1'b0;
        data_sram_rdata = 32'h0;
        drive_ms(1'b0, 32'h0, LD_NONE, 32'h0, 32'h0, 5'd0, 1'b0);

        // Reset state
        @(negedge clk);
        chk("rst rf_wen", 32'(rf_wen), 32'd0);
        chk("rst fwd_wen", 32'(forward_wb_wen), 32'd0);
        chk("rst rf_wdata", rf_wdata, 32'd0);
        chk("rst pc", debug_wb_pc, RST_PC);
        chk("rst retire", 32'(retire_count), 32'd0);
        chk("rst allowin", 32'(bus.ws_allowin), 32'd1);
        step();
        reset = 1'b0;

        // Table-driven single-load transactions
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end
        @(negedge clk);
        chk("retire after vectors", 32'(retire_count), 32'(exp_cnt % 16));
        chk("empty pc", debug_wb_pc, RST_PC);

        // Stall for 3 cycles; SRAM output changes after the first one
        drive_ms(1'b1, 32'h300, LD_LW, 32'h80000040, 32'h0, 5'd3, 1'b1);
        step();
        drive_ms(1'b1, 32'h304, LD_LB, 32'h80000041, 32'h0, 5'd4, 1'b1);
        ws_hold         = 1'b1;
        data_sram_rdata = 32'hCAFEBABE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d allowin", c), 32'(bus.ws_allowin), 32'd0);
            chk($sformatf("hold%0d rf_wen", c), 32'(rf_wen), 32'd0);
            chk($sformatf("hold%0d fwd_wen", c), 32'(forward_wb_wen), 32'd1);
            chk($sformatf("hold%0d rf_wdata", c), rf_wdata, 32'hCAFEBABE);
            chk($sformatf("hold%0d pc", c), debug_wb_pc, 32'h300);
            chk($sformatf("hold%0d retire", c), 32'(retire_count), 32'(exp_cnt % 16));
            step();
            data_sram_rdata = 32'h0000DEAD;
        end
        ws_hold      = 1'b0;
        bus.ms_valid = 1'b0;
        @(negedge clk);
        chk("release rf_wen", 32'(rf_wen), 32'd1);
        chk("release rf_wdata", rf_wdata, 32'hCAFEBABE);
        chk("release rf_waddr", 32'(rf_waddr), 32'd3);
        step();
        exp_cnt++;
        @(negedge clk);
        chk("post-release rf_wen", 32'(rf_wen), 32'd0);
        chk("post-release pc", debug_wb_pc, RST_PC);
        chk("post-release retire", 32'(retire_count), 32'(exp_cnt % 16));
        $display("hold seq: LW pc=300 held 3 cycles -> wdata=cafebabe single commit");

        // Asynchronous reset in the middle of a FRESH cycle
        step();
        drive_ms(1'b1, 32'h400, LD_LW, 32'h80000080, 32'h0, 5'd7, 1'b1);
        step();
        bus.ms_valid    = 1'b0;
        data_sram_rdata = 32'h55555555;
        #2;
        reset = 1'b1;
        #1;
        chk("async rst rf_wen", 32'(rf_wen), 32'd0);
        chk("async rst fwd_wen", 32'(forward_wb_wen), 32'd0);
        chk("async rst rf_waddr", 32'(rf_waddr), 32'd0);
        chk("async rst rf_wdata", rf_wdata, 32'd0);
        chk("async rst fwd_regsrc", 32'(forward_wb_regsrc), 32'd0);
        chk("async rst pc", debug_wb_pc, RST_PC);
        chk("async rst retire", 32'(retire_count), 32'd0);
        step();
        reset   = 1'b0;
        exp_cnt = 0;
        $display("reset seq: reset mid-FRESH -> outputs cleared");

        // Back-to-back commits up to 15, stall, then wrap to 0
        for (int k = 0; k < 16; k++) begin
            drive_ms(1'b1, 32'h2000 + 32'(k * 4), LD_LW, 32'h80000100, 32'h0, 5'd9, 1'b1);
            step();
        end
        chk("b2b retire 15", 32'(retire_count), 32'd15);
        ws_hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("wrap hold%0d rf_wen", c), 32'(rf_wen), 32'd0);
            chk($sformatf("wrap hold%0d pc", c), debug_wb_pc, 32'h203C);
            step();
            chk($sformatf("wrap hold%0d retire", c), 32'(retire_count), 32'd15);
        end
        ws_hold      = 1'b0;
        bus.ms_valid = 1'b0;
        @(negedge clk);
        chk("wrap commit rf_wen", 32'(rf_wen), 32'd1);
        step();
        @(negedge clk);
        chk("wrap retire 0", 32'(retire_count), 32'd0);
        chk("wrap empty pc", debug_wb_pc, RST_PC);
        $display("wrap seq: 16 commits with 2 held cycles -> retire_count=0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
